elbeth_fetch_unit: RTL and testbench

ELBETH_FETCH_UNIT -- requirements
Module: elbeth_fetch_unit

---
 rtl/elbeth_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_elbeth_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_fetch_unit.sv
// rtl/elbeth_fetch_unit.sv - instruction fetch unit with prefetch FIFO and redirect handling
//
// Purpose: issues one instruction-memory read at a time, buffers returned words
// in a small prefetch FIFO, and hands them to decode in fetch-address order.
// A redirect flushes the FIFO and restarts fetching at the new target; a
// response still in flight at redirect time is waited out and discarded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_en/imem_addr        memory request and byte address (held until imem_ready)
//   imem_rw/imem_out_data    write enables / write data, tied to zero (read-only port)
//   imem_in_data/imem_ready  read data and completion strobe
//   imem_error               access fault, qualified by imem_ready
//   redirect_valid/_pc       redirect pulse and target address
//   inst_valid/inst_ready    decode handshake
//   inst_data/_pc/_error     head entry (all zero while inst_valid=0)
//
// Build option: ELBETH_FETCH_ERR_EN enables fault reporting and the HALT state.

module elbeth_fetch_unit #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [7:0]  imem_addr,
  output logic [3:0]  imem_rw,
  output logic [31:0] imem_out_data,
  input  logic [31:0] imem_in_data,
  input  logic        imem_ready,
  input  logic        imem_error,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [7:0]  inst_pc,
  output logic        inst_error
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [7:0]    req_addr_q, req_addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          valid_q;
  logic          push, pop, err_bit;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [7:0]    fifo_pc   [FIFO_DEPTH];
  logic          fifo_err  [FIFO_DEPTH];

`ifdef ELBETH_FETCH_ERR_EN
  assign err_bit = imem_error;
`else
  logic unused_imem_error;
  assign unused_imem_error = imem_error;
  assign err_bit           = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over any same-cycle push or pop.
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      case (state_q)
        S_REQ, S_DROP: begin
          if (imem_ready) begin
            state_d    = S_REQ;
            req_addr_d = redirect_pc;
          end else begin
            // Old request must still complete at its original address.
            state_d = S_DROP;
          end
        end
        default: begin
          state_d    = S_REQ;
          req_addr_d = redirect_pc;
        end
      endcase
    end else begin
      push    = (state_q == S_REQ) && imem_ready;
      pop     = valid_q && inst_ready;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      case (state_q)
        S_IDLE: begin
          if (count_q < DEPTH_C) begin
            state_d    = S_REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            fetch_pc_d = fetch_pc_q + 8'd4;
`ifdef ELBETH_FETCH_ERR_EN
            if (imem_error) begin
              state_d = S_HALT;
            end else
`endif
            if (count_d < DEPTH_C) begin
              req_addr_d = fetch_pc_q + 8'd4;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            state_d    = S_REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: every read is masked by valid_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= imem_in_data;
      fifo_pc[wr_ptr_q]   <= req_addr_q;
      fifo_err[wr_ptr_q]  <= err_bit;
    end
  end

  assign imem_en       = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr     = req_addr_q;
  assign imem_rw       = 4'b0000;
  assign imem_out_data = 32'h0;
  assign inst_valid    = valid_q;
  assign inst_data     = valid_q ? fifo_data[rd_ptr_q] : 32'h0;
  assign inst_pc       = valid_q ? fifo_pc[rd_ptr_q]   : 8'h0;
  assign inst_error    = valid_q ? fifo_err[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// tb/tb_elbeth_fetch_unit.sv - scoreboard testbench for elbeth_fetch_unit

module tb_elbeth_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [3:0]  imem_rw;
  logic [31:0] imem_out_data;
  logic [31:0] imem_in_data;
  logic        imem_ready;
  logic        imem_error;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_error;

  elbeth_fetch_unit #(.RESET_PC(8'h00), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rw(imem_rw),
    .imem_out_data(imem_out_data), .imem_in_data(imem_in_data),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_error(inst_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
    logic        err;
  } inst_t;

  inst_t      exp_q[$];
  logic [7:0] addr_log[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         lat      = 1;
  logic       err_en   = 1'b0;
  logic [7:0] err_addr = 8'h10;
  int         wait_cnt = 0;
  logic       busy     = 1'b0;
  logic [7:0] cur_addr = 8'h0;
  int         idx;
  logic       found;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, 8'hC3, a, ~a};
  endfunction

  function automatic logic [7:0] log_at(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return 8'hxx;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [7:0] pc, input logic err);
    inst_t e;
    e.pc   = pc;
    e.data = mem_word(pc);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic redirect(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
  endtask

  // Memory responder: answers each request after lat cycles, logs request addresses.
  always @(negedge clk) begin
    if (imem_ready) busy = 1'b0;
    imem_ready   = 1'b0;
    imem_error   = 1'b0;
    imem_in_data = 32'h0;
    if (imem_en) begin
      if (!busy) begin
        busy     = 1'b1;
        wait_cnt = 0;
        cur_addr = imem_addr;
        addr_log.push_back(imem_addr);
      end else begin
        check_eq("addr_hold", imem_addr, cur_addr);
      end
      wait_cnt++;
      if (wait_cnt >= lat) begin
        imem_ready   = 1'b1;
        imem_in_data = mem_word(imem_addr);
        imem_error   = err_en && (imem_addr == err_addr);
      end
    end else begin
      busy = 1'b0;
    end
  end

  // Decode-side monitor: compares every accepted instruction against the scoreboard.
  always @(negedge clk) begin
    inst_t e;
    if (rst) begin
      if (inst_valid && inst_ready && !redirect_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("inst_pc", inst_pc, e.pc);
        check_eq("inst_data", inst_data, e.data);
        check_eq("inst_error", inst_error, e.err);
      end else if (!inst_valid) begin
        check_eq("idle_zero", {inst_data, inst_pc, inst_error}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h0;
    imem_ready     = 1'b0;
    imem_error     = 1'b0;
    imem_in_data   = 32'h0;
    repeat (3) tick();
    check_eq("rst_imem_en", imem_en, 0);
    check_eq("rst_imem_addr", imem_addr, 8'h00);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst_fields", {inst_data, inst_pc, inst_error}, 0);
    check_eq("imem_rw", imem_rw, 0);
    check_eq("imem_out_data", imem_out_data, 0);
    rst = 1'b1;
    #1;
    check_eq("rel_imem_en", imem_en, 0);

    // Sequential fetch, 1-cycle memory, decode always ready.
    for (int i = 0; i < 4; i++) push_exp(8'(i * 4), 1'b0);
    wait_drain("seq_drain");
    check_eq("seq_addr0", log_at(0), 8'h00);
    check_eq("seq_addr1", log_at(1), 8'h04);
    check_eq("seq_addr2", log_at(2), 8'h08);

    // Decode stalled: FIFO fills to two entries and requests stop.
    inst_ready = 1'b0;
    do_reset();
    idx = addr_log.size();
    repeat (10) tick();
    check_eq("full_valid", inst_valid, 1);
    check_eq("full_imem_en", imem_en, 0);
    check_eq("full_req_count", addr_log.size() - idx, 2);
    check_eq("full_head_pc", inst_pc, 8'h00);
    push_exp(8'h00, 1'b0);
    push_exp(8'h04, 1'b0);
    push_exp(8'h08, 1'b0);
    inst_ready = 1'b1;
    wait_drain("full_drain");
    check_eq("full_third_addr", log_at(idx + 2), 8'h08);

    // Redirect while 0x08 is pending with slow memory.
    lat = 4;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (imem_en && imem_addr == 8'h08) found = 1'b1;
      else tick();
    end
    check_eq("drop_found", found, 1);
    redirect(8'h40);
    push_exp(8'h40, 1'b0);
    push_exp(8'h44, 1'b0);
    tick();
    redirect_valid = 1'b0;
    check_eq("drop_en", imem_en, 1);
    check_eq("drop_addr", imem_addr, 8'h08);
    idx = addr_log.size();
    tick();
    check_eq("drop_addr_hold", imem_addr, 8'h08);
    wait_drain("drop_drain");
    check_eq("drop_next_addr", log_at(idx), 8'h40);

    // Wrap-around of the fetch address.
    lat = 1;
    redirect(8'hFC);
    push_exp(8'hFC, 1'b0);
    push_exp(8'h00, 1'b0);
    push_exp(8'h04, 1'b0);
    tick();
    redirect_valid = 1'b0;
    wait_drain("wrap_drain");

    // Access fault at 0x10.
    err_en = 1'b1;
    redirect(8'h08);
    push_exp(8'h08, 1'b0);
    push_exp(8'h0C, 1'b0);
`ifdef ELBETH_FETCH_ERR_EN
    push_exp(8'h10, 1'b1);
`else
    push_exp(8'h10, 1'b0);
    push_exp(8'h14, 1'b0);
`endif
    tick();
    redirect_valid = 1'b0;
    wait_drain("err_drain");
`ifdef ELBETH_FETCH_ERR_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("halt_no_req", imem_en, 0);
    end
    check_eq("halt_last_addr", log_at(addr_log.size() - 1), 8'h10);
`endif
    err_en = 1'b0;
    redirect(8'h20);
    tick();
    redirect_valid = 1'b0;
    check_eq("resume_en", imem_en, 1);
    check_eq("resume_addr", imem_addr, 8'h20);

    // Reset asserted between edges in the middle of a request.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_en) found = 1'b1;
      else tick();
    end
    check_eq("mid_found", found, 1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_en", imem_en, 0);
    check_eq("mid_rst_valid", inst_valid, 0);
    check_eq("mid_rst_addr", imem_addr, 8'h00);
    tick();
    exp_q.delete();
    rst = 1'b1;
    #1;
    check_eq("mid_rel_en", imem_en, 0);
    idx = addr_log.size();
    lat = 1;
    push_exp(8'h00, 1'b0);
    push_exp(8'h04, 1'b0);
    push_exp(8'h08, 1'b0);
    wait_drain("mid_drain");
    check_eq("mid_first_addr", log_at(idx), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
